cache_repl_unit: RTL and testbench

Per-set replacement-state unit for the set-associative cache. Tracks way usage order and way valid bits for every set, and reports the victim way for a queried set. Supports a true-LRU mode and a FIFO mode, invalidate-aware victim selection, and a multi-cycle flush sweep. Sits beside the tag/data arrays and is driven by the cache controller FSM on each hit, fill and invalidate.

---
 rtl/cache_repl_pkg.sv | 18 +
 rtl/cache_repl_unit_if.sv | 34 +++
 rtl/cache_repl_unit_repl_order_update.sv | 74 +++++++
 rtl/cache_repl_unit.sv | 157 +++++++++++++++
 tb/tb_cache_repl_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_repl_pkg.sv
// Shared constants, types and flush FSM encoding for the cache replacement unit.
package cache_repl_pkg;

    localparam int unsigned POLICY_LRU  = 0;
    localparam int unsigned POLICY_FIFO = 1;

    localparam int unsigned DEF_WAYS = 4;
    localparam int unsigned DEF_SETS = 16;

    typedef logic [$clog2(DEF_WAYS)-1:0] way_t;
    typedef logic [$clog2(DEF_SETS)-1:0] set_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } flush_state_t;

endpackage

// File: rtl/cache_repl_unit_if.sv
// Controller-side bus of the replacement unit: access, invalidate, flush and victim query.
interface cache_repl_unit_if
    import cache_repl_pkg::*;
#(
    parameter int unsigned WAYS = DEF_WAYS,
    parameter int unsigned SETS = DEF_SETS
) ();

    logic                      flush;
    logic                      busy;
    logic                      acc_valid;
    logic [$clog2(SETS)-1:0]   acc_set;
    logic [$clog2(WAYS)-1:0]   acc_way;
    logic                      acc_fill;
    logic                      inv_valid;
    logic [$clog2(SETS)-1:0]   inv_set;
    logic [$clog2(WAYS)-1:0]   inv_way;
    logic [$clog2(SETS)-1:0]   q_set;
    logic [$clog2(WAYS)-1:0]   victim_way;
    logic                      victim_free;

    modport master (
        output flush, acc_valid, acc_set, acc_way, acc_fill,
               inv_valid, inv_set, inv_way, q_set,
        input  busy, victim_way, victim_free
    );

    modport slave (
        input  flush, acc_valid, acc_set, acc_way, acc_fill,
               inv_valid, inv_set, inv_way, q_set,
        output busy, victim_way, victim_free
    );

endinterface

// File: rtl/cache_repl_unit_repl_order_update.sv
// Next order list and valid bits for one set: access reorder first, then invalidate move.
module repl_order_update
    import cache_repl_pkg::*;
#(
    parameter int unsigned WAYS   = DEF_WAYS,
    parameter int unsigned POLICY = POLICY_LRU,
    localparam int unsigned WW    = $clog2(WAYS)
) (
    input  logic [WW-1:0]   i_order [WAYS],
    input  logic [WAYS-1:0] i_valid,
    input  logic            i_acc_en,
    input  logic [WW-1:0]   i_acc_way,
    input  logic            i_acc_fill,
    input  logic            i_inv_en,
    input  logic [WW-1:0]   i_inv_way,
    output logic [WW-1:0]   o_order [WAYS],
    output logic [WAYS-1:0] o_valid
);

    int unsigned     w_acc_k;
    int unsigned     w_inv_k;
    logic            w_acc_move;
    logic            w_inv_apply;
    logic [WW-1:0]   w_mid [WAYS];
    logic [WAYS-1:0] w_vmid;

    always_comb begin
        w_acc_k = 0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (i_order[i] == i_acc_way) begin
                w_acc_k = i;
            end
        end
        w_acc_move = i_acc_en && ((POLICY == POLICY_LRU) || i_acc_fill);
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_acc_move || (i < w_acc_k)) begin
                w_mid[i] = i_order[i];
            end else if (i < WAYS - 1) begin
                w_mid[i] = i_order[(i + 1) % WAYS];
            end else begin
                w_mid[i] = i_acc_way;
            end
        end
        w_vmid = i_valid;
        if (i_acc_en && i_acc_fill) begin
            w_vmid = i_valid | (WAYS'(1) << i_acc_way);
        end
    end

    // Invalidate runs on the already-reordered list; a clash on the same way drops it.
    always_comb begin
        w_inv_apply = i_inv_en && !(i_acc_en && (i_acc_way == i_inv_way));
        w_inv_k     = 0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (w_mid[i] == i_inv_way) begin
                w_inv_k = i;
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_inv_apply || (i > w_inv_k)) begin
                o_order[i] = w_mid[i];
            end else if (i == 0) begin
                o_order[i] = i_inv_way;
            end else begin
                o_order[i] = w_mid[(i + WAYS - 1) % WAYS];
            end
        end
        o_valid = w_vmid;
        if (w_inv_apply) begin
            o_valid = w_vmid & ~(WAYS'(1) << i_inv_way);
        end
    end

endmodule

// File: rtl/cache_repl_unit.sv
// Per-set replacement state (order list + valid bits), victim selection and flush sweep.
module cache_repl_unit
    import cache_repl_pkg::*;
#(
    parameter int unsigned WAYS   = DEF_WAYS,
    parameter int unsigned SETS   = DEF_SETS,
    parameter int unsigned POLICY = POLICY_LRU
) (
    input logic               clk,
    input logic               rst,
    cache_repl_unit_if.slave  bus
);

    localparam int unsigned WW = $clog2(WAYS);
    localparam int unsigned SW = $clog2(SETS);

    logic [WW-1:0]   r_order [SETS][WAYS];
    logic [WAYS-1:0] r_valid [SETS];
    logic [SW-1:0]   r_cnt;
    flush_state_t    r_state;
    flush_state_t    w_state_nxt;

    logic            w_acc_en;
    logic            w_inv_en;
    logic            w_same;
    logic            w_inv_b;
    logic [WW-1:0]   w_cur_a [WAYS];
    logic [WW-1:0]   w_cur_b [WAYS];
    logic [WW-1:0]   w_order_a [WAYS];
    logic [WW-1:0]   w_order_b [WAYS];
    logic [WAYS-1:0] w_valid_a;
    logic [WAYS-1:0] w_valid_b;
    logic [WW-1:0]   w_vic_way;
    logic            w_vic_free;
    logic [WAYS-1:0] w_seen;
    logic            w_perm_ok;

    assign w_acc_en = bus.acc_valid && (r_state == ST_IDLE);
    assign w_inv_en = bus.inv_valid && (r_state == ST_IDLE);
    assign w_same   = w_acc_en && w_inv_en && (bus.acc_set == bus.inv_set);
    assign w_inv_b  = w_inv_en && !w_same;

    always_comb begin
        for (int unsigned i = 0; i < WAYS; i++) begin
            w_cur_a[i] = r_order[bus.acc_set][i];
            w_cur_b[i] = r_order[bus.inv_set][i];
        end
    end

    // Instance A owns the access set and also takes a same-set invalidate.
    repl_order_update #(
        .WAYS   (WAYS),
        .POLICY (POLICY)
    ) u_upd_a (
        .i_order    (w_cur_a),
        .i_valid    (r_valid[bus.acc_set]),
        .i_acc_en   (w_acc_en),
        .i_acc_way  (bus.acc_way),
        .i_acc_fill (bus.acc_fill),
        .i_inv_en   (w_same),
        .i_inv_way  (bus.inv_way),
        .o_order    (w_order_a),
        .o_valid    (w_valid_a)
    );

    repl_order_update #(
        .WAYS   (WAYS),
        .POLICY (POLICY)
    ) u_upd_b (
        .i_order    (w_cur_b),
        .i_valid    (r_valid[bus.inv_set]),
        .i_acc_en   (1'b0),
        .i_acc_way  ('0),
        .i_acc_fill (1'b0),
        .i_inv_en   (w_inv_b),
        .i_inv_way  (bus.inv_way),
        .o_order    (w_order_b),
        .o_valid    (w_valid_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.flush) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (r_cnt == SW'(SETS - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned i = 0; i < WAYS; i++) begin
                    r_order[s][i] <= WW'(i);
                end
                r_valid[s] <= '0;
            end
        end else if (r_state == ST_SWEEP) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                r_order[r_cnt][i] <= WW'(i);
            end
            r_valid[r_cnt] <= '0;
            r_cnt          <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
            if (w_acc_en) begin
                r_order[bus.acc_set] <= w_order_a;
                r_valid[bus.acc_set] <= w_valid_a;
            end
            if (w_inv_b) begin
                r_order[bus.inv_set] <= w_order_b;
                r_valid[bus.inv_set] <= w_valid_b;
            end
        end
    end

    always_comb begin
        w_vic_free = 1'b0;
        w_vic_way  = r_order[bus.q_set][0];
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_vic_free && !r_valid[bus.q_set][i]) begin
                w_vic_free = 1'b1;
                w_vic_way  = WW'(i);
            end
        end
    end

    assign bus.victim_way  = w_vic_way;
    assign bus.victim_free = w_vic_free;
    assign bus.busy        = (r_state == ST_SWEEP);

    always_comb begin
        w_perm_ok = 1'b1;
        w_seen    = '0;
        for (int unsigned s = 0; s < SETS; s++) begin
            w_seen = '0;
            for (int unsigned i = 0; i < WAYS; i++) begin
                w_seen[r_order[s][i]] = 1'b1;
            end
            if (w_seen != '1) begin
                w_perm_ok = 1'b0;
            end
        end
    end

    a_order_perm: assert property (@(posedge clk) disable iff (rst) w_perm_ok);

endmodule

// File: tb/tb_cache_repl_unit.sv
// Scoreboard bench for cache_repl_unit: LRU and FIFO instances driven with identical stimulus.
module tb_cache_repl_unit;
    import cache_repl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic flush, acc_valid, acc_fill, inv_valid;
    set_t acc_set, inv_set, q_set;
    way_t acc_way, inv_way;

    cache_repl_unit_if #(.WAYS(4), .SETS(16)) bus_l ();
    cache_repl_unit_if #(.WAYS(4), .SETS(16)) bus_f ();

    assign bus_l.flush     = flush;
    assign bus_l.acc_valid = acc_valid;
    assign bus_l.acc_set   = acc_set;
    assign bus_l.acc_way   = acc_way;
    assign bus_l.acc_fill  = acc_fill;
    assign bus_l.inv_valid = inv_valid;
    assign bus_l.inv_set   = inv_set;
    assign bus_l.inv_way   = inv_way;
    assign bus_l.q_set     = q_set;
    assign bus_f.flush     = flush;
    assign bus_f.acc_valid = acc_valid;
    assign bus_f.acc_set   = acc_set;
    assign bus_f.acc_way   = acc_way;
    assign bus_f.acc_fill  = acc_fill;
    assign bus_f.inv_valid = inv_valid;
    assign bus_f.inv_set   = inv_set;
    assign bus_f.inv_way   = inv_way;
    assign bus_f.q_set     = q_set;

    cache_repl_unit #(.WAYS(4), .SETS(16), .POLICY(POLICY_LRU))  dut   (.clk(clk), .rst(rst), .bus(bus_l));
    cache_repl_unit #(.WAYS(4), .SETS(16), .POLICY(POLICY_FIFO)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    typedef struct {
        string       name;
        bit          fifo;
        int          set;
        int          way;
        bit          free;
        bit          busy;
        bit          chk_order;
        logic [15:0] order;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [15:0] order_of(input bit fifo, input int s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[15 - 4*i -: 4] = fifo ? {2'b00, dut_f.r_order[s][i]} : {2'b00, dut.r_order[s][i]};
        end
        return r;
    endfunction

    function automatic void compare(input string nm, input string field, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0h expected %0h", nm, field, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.name, "victim_way",  int'(e.fifo ? bus_f.victim_way  : bus_l.victim_way),  e.way);
            compare(e.name, "victim_free", int'(e.fifo ? bus_f.victim_free : bus_l.victim_free), int'(e.free));
            compare(e.name, "busy",        int'(e.fifo ? bus_f.busy        : bus_l.busy),        int'(e.busy));
            if (e.chk_order) begin
                compare(e.name, "order", int'(order_of(e.fifo, e.set)), int'(e.order));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input bit fifo, input int s, input int way, input bit free,
                       input bit bsy, input bit co, input logic [15:0] ord);
        exp_t x;
        q_set = set_t'(s);
        x.name = nm; x.fifo = fifo; x.set = s; x.way = way; x.free = free;
        x.busy = bsy; x.chk_order = co; x.order = ord;
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic access(input int s, input int w, input bit fill);
        acc_valid = 1'b1; acc_set = set_t'(s); acc_way = way_t'(w); acc_fill = fill;
        cyc();
        acc_valid = 1'b0;
    endtask

    task automatic inval(input int s, input int w);
        inv_valid = 1'b1; inv_set = set_t'(s); inv_way = way_t'(w);
        cyc();
        inv_valid = 1'b0;
    endtask

    task automatic both(input int as, input int aw, input bit fill, input int is, input int iw);
        acc_valid = 1'b1; acc_set = set_t'(as); acc_way = way_t'(aw); acc_fill = fill;
        inv_valid = 1'b1; inv_set = set_t'(is); inv_way = way_t'(iw);
        cyc();
        acc_valid = 1'b0; inv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; acc_valid = 1'b0; acc_fill = 1'b0; inv_valid = 1'b0;
        acc_set = '0; inv_set = '0; acc_way = '0; inv_way = '0; q_set = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_q3", 0, 3, 0, 1, 0, 1, 16'h0123);
        for (int s = 0; s < 16; s++) chk("rst_all", 0, s, 0, 1, 0, 1, 16'h0123);

        for (int w = 0; w < 4; w++) access(5, w, 1'b1);
        chk("fill5",   0, 5, 0, 0, 0, 1, 16'h0123);
        chk("fill5_f", 1, 5, 0, 0, 0, 1, 16'h0123);
        access(5, 0, 1'b0);
        chk("hit5",    0, 5, 1, 0, 0, 1, 16'h1230);
        chk("hit5_f",  1, 5, 0, 0, 0, 1, 16'h0123);

        inval(5, 2);
        chk("inv5",    0, 5, 2, 1, 0, 1, 16'h2130);
        chk("inv5_f",  1, 5, 2, 1, 0, 1, 16'h2013);
        access(5, 2, 1'b1);
        chk("refill5",   0, 5, 1, 0, 0, 1, 16'h1302);
        chk("refill5_f", 1, 5, 0, 0, 0, 1, 16'h0132);

        for (int w = 0; w < 4; w++) access(7, w, 1'b1);
        both(7, 3, 1'b0, 7, 3);
        chk("same_way",   0, 7, 0, 0, 0, 1, 16'h0123);
        chk("same_way_f", 1, 7, 0, 0, 0, 1, 16'h0123);
        both(7, 1, 1'b0, 7, 2);
        chk("same_set",   0, 7, 2, 1, 0, 1, 16'h2031);
        chk("same_set_f", 1, 7, 2, 1, 0, 1, 16'h2013);

        both(9, 1, 1'b1, 5, 3);
        chk("diff_acc",   0, 9, 0, 1, 0, 1, 16'h0231);
        chk("diff_inv",   0, 5, 3, 1, 0, 1, 16'h3102);
        chk("diff_acc_f", 1, 9, 0, 1, 0, 1, 16'h0231);
        chk("diff_inv_f", 1, 5, 3, 1, 0, 1, 16'h3012);

        // Flush with access strobes held throughout the sweep
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        acc_valid = 1'b1; acc_set = set_t'(15); acc_way = way_t'(3); acc_fill = 1'b1;
        chk("flush_busy", 0, 0, 0, 1, 1, 0, 16'h0000);
        for (int c = 1; c < 16; c++) begin
            cyc();
            chk("flush_busy", 0, 0, 0, 1, 1, 0, 16'h0000);
        end
        cyc();
        acc_valid = 1'b0;
        chk("flush_done", 0, 0, 0, 1, 0, 0, 16'h0000);
        for (int s = 0; s < 16; s++) begin
            chk("post_flush",   0, s, 0, 1, 0, 1, 16'h0123);
            chk("post_flush_f", 1, s, 0, 1, 0, 1, 16'h0123);
        end

        access(5, 0, 1'b1);
        chk("pre_abort", 0, 5, 1, 1, 0, 1, 16'h1230);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (5) cyc();
        rst = 1'b1;
        chk("abort_busy", 0, 0, 0, 1, 0, 0, 16'h0000);
        chk("abort_s5",   0, 5, 0, 1, 0, 1, 16'h0123);
        chk("abort_s12",  0, 12, 0, 1, 0, 1, 16'h0123);
        cyc();
        rst = 1'b0;
        chk("post_abort", 0, 5, 0, 1, 0, 1, 16'h0123);

        repeat (2) cyc();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
